// File: rtl/load_store_unit.sv
// load_store_unit: RV32I memory-stage load/store unit.
// Captures one memory operation from execute, classifies faults, drives a
// word-addressed request/grant/response data-memory port and returns a
// registered, aligned and extended load result to the writeback mux.
module load_store_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic [31:0] load_data,
  output logic        busy,
  output logic        done,
  output logic        misaligned,
  output logic        illegal
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  funct3_q;
  logic [1:0]  off_q;
  logic        mem_we_q;
  logic [31:0] mem_addr_q;
  logic [3:0]  mem_wstrb_q;
  logic [31:0] mem_wdata_q;
  logic [31:0] load_data_q;
  logic        misaligned_q;
  logic        illegal_q;

  logic        accept_s;
  logic        illegal_s;
  logic        misaligned_s;

  // funct3 encodings a load or store may legally use
  function automatic logic is_illegal(input logic is_store, input logic [2:0] f3);
    logic bad;
    if (is_store) begin
      bad = (f3 != 3'b000) && (f3 != 3'b001) && (f3 != 3'b010);
    end else begin
      bad = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    end
    return bad;
  endfunction

  // halfword needs even address, word needs 4-byte alignment
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
    logic bad;
    case (f3[1:0])
      2'b01:   bad = off[0];
      2'b10:   bad = (off != 2'b00);
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

  // byte lanes written by a store
  function automatic logic [3:0] store_strb(input logic [2:0] f3, input logic [1:0] off);
    logic [3:0] s;
    case (f3)
      3'b000:  s = 4'b0001 << off;
      3'b001:  s = 4'b0011 << off;
      3'b010:  s = 4'b1111;
      default: s = 4'b0000;
    endcase
    return s;
  endfunction

  // store data replicated across every lane it may land in
  function automatic logic [31:0] store_word(input logic [2:0] f3, input logic [31:0] sd);
    logic [31:0] w;
    case (f3)
      3'b000:  w = {4{sd[7:0]}};
      3'b001:  w = {2{sd[15:0]}};
      3'b010:  w = sd;
      default: w = 32'h0000_0000;
    endcase
    return w;
  endfunction

  // shift the addressed bytes down and extend per funct3
  function automatic logic [31:0] load_fmt(input logic [2:0] f3, input logic [1:0] off,
                                           input logic [31:0] rd);
    logic [31:0] r;
    logic [31:0] v;
    r = rd >> {off, 3'b000};
    case (f3)
      3'b000:  v = {{24{r[7]}}, r[7:0]};
      3'b001:  v = {{16{r[15]}}, r[15:0]};
      3'b010:  v = rd;
      3'b100:  v = {24'h00_0000, r[7:0]};
      3'b101:  v = {16'h0000, r[15:0]};
      default: v = 32'h0000_0000;
    endcase
    return v;
  endfunction

  assign accept_s     = (state_q == IDLE) && start;
  assign illegal_s    = is_illegal(we, funct3);
  assign misaligned_s = is_misaligned(funct3, addr[1:0]);

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next-state logic; faults skip the memory port entirely
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (illegal_s || misaligned_s) begin
            state_d = DONE;
          end else begin
            state_d = REQ;
          end
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        if (mem_gnt) begin
          state_d = mem_we_q ? DONE : WAIT;
        end else begin
          state_d = REQ;
        end
      end
      WAIT: begin
        if (mem_rvalid) begin
          state_d = DONE;
        end else begin
          state_d = WAIT;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // status outputs decoded from the state register only
  always_comb begin
    mem_req = 1'b0;
    busy    = 1'b1;
    done    = 1'b0;
    case (state_q)
      IDLE:    busy = 1'b0;
      REQ:     mem_req = 1'b1;
      WAIT:    mem_req = 1'b0;
      DONE:    done = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  // operation capture, request payload, fault flags and load result
  always_ff @(posedge clk) begin
    if (rst) begin
      funct3_q     <= 3'b000;
      off_q        <= 2'b00;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= 32'h0000_0000;
      mem_wstrb_q  <= 4'b0000;
      mem_wdata_q  <= 32'h0000_0000;
      load_data_q  <= 32'h0000_0000;
      misaligned_q <= 1'b0;
      illegal_q    <= 1'b0;
    end else begin
      if (accept_s) begin
        funct3_q     <= funct3;
        off_q        <= addr[1:0];
        illegal_q    <= illegal_s;
        misaligned_q <= misaligned_s && !illegal_s;
        if (!illegal_s && !misaligned_s) begin
          mem_we_q    <= we;
          mem_addr_q  <= {addr[31:2], 2'b00};
          mem_wstrb_q <= we ? store_strb(funct3, addr[1:0]) : 4'b0000;
          mem_wdata_q <= we ? store_word(funct3, store_data) : 32'h0000_0000;
        end
      end
      if ((state_q == WAIT) && mem_rvalid) begin
        load_data_q <= load_fmt(funct3_q, off_q, mem_rdata);
      end
    end
  end

  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wstrb  = mem_wstrb_q;
  assign mem_wdata  = mem_wdata_q;
  assign load_data  = load_data_q;
  assign misaligned = misaligned_q;
  assign illegal    = illegal_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed self-checking bench for load_store_unit.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst, start, we;
  logic [2:0]  funct3;
  logic [31:0] addr, store_data;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;
  logic [31:0] load_data;
  logic        busy, done, misaligned, illegal;

  int checks = 0;
  int errors = 0;
  int done_cnt;

  load_store_unit dut (
    .clk(clk), .rst(rst), .start(start), .we(we), .funct3(funct3),
    .addr(addr), .store_data(store_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .load_data(load_data), .busy(busy), .done(done),
    .misaligned(misaligned), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // present an operation for exactly one cycle (cycle 0), return in cycle 1
  task automatic issue(input logic w, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] sd);
    we = w; funct3 = f3; addr = a; store_data = sd; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // minimum-latency load: grant in cycle 1, rvalid in cycle 2, done in cycle 3
  task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] rd, input logic [31:0] exp);
    issue(1'b0, f3, a, 32'h0);
    chk({tag, "_req"}, {31'd0, mem_req}, 32'd1);
    chk({tag, "_addr"}, mem_addr, {a[31:2], 2'b00});
    chk({tag, "_wstrb"}, {28'd0, mem_wstrb}, 32'd0);
    chk({tag, "_we"}, {31'd0, mem_we}, 32'd0);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    chk({tag, "_c2done"}, {31'd0, done}, 32'd0);
    chk({tag, "_c2req"}, {31'd0, mem_req}, 32'd0);
    mem_rvalid = 1'b1; mem_rdata = rd;
    tick();
    mem_rvalid = 1'b0; mem_rdata = 32'h0;
    chk({tag, "_c3done"}, {31'd0, done}, 32'd1);
    chk({tag, "_data"}, load_data, exp);
    tick();
    chk({tag, "_idle"}, {30'd0, busy, done}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; we = 1'b0; funct3 = 3'b000; addr = 32'h0;
    store_data = 32'h0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    tick(); tick();
    rst = 1'b0;

    // reset state
    chk("rst_load_data", load_data, 32'h0);
    chk("rst_flags", {28'd0, busy, done, misaligned, illegal}, 32'd0);
    chk("rst_mem_ctl", {26'd0, mem_req, mem_we, mem_wstrb}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    tick();
    chk("idle_busy", {31'd0, busy}, 32'd0);

    // loads
    do_load("lb", 3'b000, 32'h0000_1003, 32'h80FF_1234, 32'hFFFF_FF80);
    do_load("lhu", 3'b101, 32'h0000_2002, 32'hBEEF_0000, 32'h0000_BEEF);
    do_load("lh", 3'b001, 32'h0000_2002, 32'hBEEF_0000, 32'hFFFF_BEEF);

    // SB: replicated byte, strobe lane 1, done in cycle 2
    issue(1'b1, 3'b000, 32'h0000_0011, 32'h1234_56AB);
    chk("sb_req", {31'd0, mem_req}, 32'd1);
    chk("sb_busy", {31'd0, busy}, 32'd1);
    chk("sb_we", {31'd0, mem_we}, 32'd1);
    chk("sb_addr", mem_addr, 32'h0000_0010);
    chk("sb_wdata", mem_wdata, 32'hABAB_ABAB);
    chk("sb_wstrb", {28'd0, mem_wstrb}, 32'h2);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    chk("sb_done", {31'd0, done}, 32'd1);
    chk("sb_load_hold", load_data, 32'hFFFF_BEEF);
    tick();

    // SW
    issue(1'b1, 3'b010, 32'h0000_0020, 32'hDEAD_BEEF);
    chk("sw_wstrb", {28'd0, mem_wstrb}, 32'hF);
    chk("sw_wdata", mem_wdata, 32'hDEAD_BEEF);
    chk("sw_addr", mem_addr, 32'h0000_0020);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    chk("sw_done", {31'd0, done}, 32'd1);
    chk("sw_load_hold", load_data, 32'hFFFF_BEEF);
    tick();

    // misaligned LW: done in cycle 1, no request
    issue(1'b0, 3'b010, 32'h0000_0006, 32'h0);
    chk("lw_mis_done", {31'd0, done}, 32'd1);
    chk("lw_mis_flags", {30'd0, misaligned, illegal}, 32'h2);
    chk("lw_mis_req", {31'd0, mem_req}, 32'd0);
    tick();
    chk("lw_mis_hold", {29'd0, busy, misaligned, illegal}, 32'h2);

    // illegal load funct3 011
    issue(1'b0, 3'b011, 32'h0000_0000, 32'h0);
    chk("ld011_flags", {29'd0, done, misaligned, illegal}, 32'h5);
    chk("ld011_req", {31'd0, mem_req}, 32'd0);
    tick();

    // illegal beats misaligned (funct3 110, odd address)
    issue(1'b0, 3'b110, 32'h0000_0001, 32'h0);
    chk("prio_flags", {29'd0, done, misaligned, illegal}, 32'h5);
    tick();

    // misaligned SH
    issue(1'b1, 3'b001, 32'h0000_0001, 32'hFFFF_FFFF);
    chk("sh_mis_flags", {29'd0, done, misaligned, illegal}, 32'h6);
    chk("sh_mis_req", {31'd0, mem_req}, 32'd0);
    tick();

    // illegal store funct3 100
    issue(1'b1, 3'b100, 32'h0000_0000, 32'h0);
    chk("st100_flags", {29'd0, done, misaligned, illegal}, 32'h5);
    chk("fault_load_hold", load_data, 32'hFFFF_BEEF);
    tick();

    // stall: gnt in cycle 4, rvalid in cycle 7, done in cycle 8
    issue(1'b0, 3'b010, 32'h0000_0040, 32'h0);
    done_cnt = 0;
    for (int k = 1; k <= 9; k++) begin
      chk($sformatf("stall_c%0d_done", k), {31'd0, done}, {31'd0, (k == 8)});
      chk($sformatf("stall_c%0d_req", k), {31'd0, mem_req}, {31'd0, (k <= 4)});
      if (k <= 4) begin
        chk($sformatf("stall_c%0d_addr", k), mem_addr, 32'h0000_0040);
        chk($sformatf("stall_c%0d_ctl", k), {27'd0, mem_we, mem_wstrb}, 32'd0);
      end
      if (done) done_cnt++;
      mem_gnt    = (k == 4);
      mem_rvalid = (k == 2) || (k == 7);
      mem_rdata  = (k == 7) ? 32'hCAFE_F00D : 32'h1111_1111;
      tick();
    end
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    chk("stall_done_cnt", done_cnt, 32'd1);
    chk("stall_data", load_data, 32'hCAFE_F00D);

    // reset while waiting for read data
    issue(1'b0, 3'b100, 32'h0000_0001, 32'h0);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    chk("wait_busy", {30'd0, busy, mem_req}, 32'h2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("wrst_flags", {28'd0, busy, done, misaligned, illegal}, 32'd0);
    chk("wrst_mem_ctl", {26'd0, mem_req, mem_we, mem_wstrb}, 32'd0);
    chk("wrst_mem_addr", mem_addr, 32'h0);
    chk("wrst_load_data", load_data, 32'h0);
    mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    tick();
    mem_rvalid = 1'b0; mem_rdata = 32'h0;
    chk("stray_rvalid_data", load_data, 32'h0);
    chk("stray_rvalid_busy", {31'd0, busy}, 32'd0);
    do_load("lbu", 3'b100, 32'h0000_0001, 32'h0000_A500, 32'h0000_00A5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
